// File: rtl/hls_byte_stream_packer.sv
// Packs an 8-bit valid/ready byte stream little-endian into NB_LANES-byte words with strobes,
// flushing a partial final word and reporting byte count and completion for each transfer.
module hls_byte_stream_packer #(
    parameter int NB_LANES = 4,
    parameter int LEN_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [8*NB_LANES-1:0] out_data_o,
    output logic [NB_LANES-1:0]   out_strb_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_W-1:0]      byte_cnt_o
);

    localparam int LANE_W = (NB_LANES > 1) ? $clog2(NB_LANES) : 1;

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    state_t                state, state_nxt;
    logic [LANE_W-1:0]     lane;
    logic [LEN_W-1:0]      len_q;
    logic [8*NB_LANES-1:0] acc;

    logic                  is_last;
    logic                  completing;
    logic                  accept;
    logic                  word_take;
    logic [8*NB_LANES-1:0] word;
    logic [NB_LANES-1:0]   strb;

    always_comb begin
        is_last    = (byte_cnt_o + LEN_W'(1)) == len_q;
        completing = (lane == LANE_W'(NB_LANES - 1)) || is_last;
        word_take  = out_valid_o & out_ready_i;
        // A completing byte may only enter when the output register is free or draining now.
        in_ready_o = (state == PACK) & (~completing | ~out_valid_o | out_ready_i);
        accept     = in_valid_i & in_ready_o;
        busy_o     = (state != IDLE);
        done_o     = (state == DONE);
        word       = '0;
        strb       = '0;
        for (int k = 0; k < NB_LANES; k++) begin
            if (LANE_W'(k) < lane) begin
                word[8*k +: 8] = acc[8*k +: 8];
                strb[k]        = 1'b1;
            end else if (LANE_W'(k) == lane) begin
                word[8*k +: 8] = in_data_i;
                strb[k]        = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = (len_i != '0) ? PACK : DONE;
            PACK:    if (accept && is_last) state_nxt = FLUSH;
            FLUSH:   if (word_take && out_last_o) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            lane        <= '0;
            len_q       <= '0;
            acc         <= '0;
            byte_cnt_o  <= '0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else if (clear_i) begin
            state       <= IDLE;
            lane        <= '0;
            len_q       <= '0;
            acc         <= '0;
            byte_cnt_o  <= '0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                len_q      <= len_i;
                byte_cnt_o <= '0;
                lane       <= '0;
            end
            if (accept) begin
                byte_cnt_o <= byte_cnt_o + LEN_W'(1);
                lane       <= completing ? '0 : lane + LANE_W'(1);
                for (int k = 0; k < NB_LANES; k++) begin
                    if (LANE_W'(k) == lane) acc[8*k +: 8] <= in_data_i;
                end
            end
            // Output register stage: loads only when free or being taken this cycle.
            if (accept && completing) begin
                out_data_o  <= word;
                out_strb_o  <= strb;
                out_last_o  <= is_last;
                out_valid_o <= 1'b1;
            end else if (word_take) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
